// File: rtl/fx_arb.sv
// Two-port arbiter/sequencer for the config register file's fx bus.
// Round-robin between host port A and local port B, with a bounded B lock.
module fx_arb #(
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic        clk_sys,
    input  logic        rst_n,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [21:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic [7:0]  a_rdata,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [21:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [7:0]  b_rdata,
    input  logic        b_lock,

    output logic [21:0] fx_waddr,
    output logic        fx_wr,
    output logic [7:0]  fx_data,
    output logic        fx_rd,
    output logic [21:0] fx_raddr,
    input  logic [7:0]  fx_q,

    output logic        busy,
    output logic        own_b
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RWAIT,
        S_RDONE
    } state_t;

    localparam logic [2:0] LAT_M1     = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
    localparam logic [7:0] LOCK_LIMIT = 8'(LOCK_MAX);

    state_t      state_q,    state_d;
    logic [2:0]  wait_q,     wait_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        last_b_q,   last_b_d;
    logic        own_b_q,    own_b_d;
    logic [21:0] fx_waddr_q, fx_waddr_d;
    logic [21:0] fx_raddr_q, fx_raddr_d;
    logic [7:0]  fx_data_q,  fx_data_d;
    logic        fx_wr_q,    fx_wr_d;
    logic        fx_rd_q,    fx_rd_d;
    logic        a_ack_q,    a_ack_d;
    logic        b_ack_q,    b_ack_d;
    logic [7:0]  a_rdata_q,  a_rdata_d;
    logic [7:0]  b_rdata_q,  b_rdata_d;
    logic        busy_q,     busy_d;

    logic        lock_ok;
    logic        grant_b;
    logic        win_we;
    logic        capture;
    logic        ack_any;

    always_comb begin
        // NOTE: every signal gets a default up front so no path can infer a latch.
        state_d    = state_q;
        wait_d     = wait_q;
        lock_cnt_d = lock_cnt_q;
        last_b_d   = last_b_q;
        own_b_d    = own_b_q;
        fx_waddr_d = fx_waddr_q;
        fx_raddr_d = fx_raddr_q;
        fx_data_d  = fx_data_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        grant_b    = 1'b0;
        win_we     = 1'b0;
        capture    = 1'b0;
        lock_ok    = last_b_q && b_lock && b_req && (lock_cnt_q < LOCK_LIMIT);

        case (state_q)
            S_IDLE: begin
                if (a_req || b_req) begin
                    // Tie goes to the port that did not own last, unless B's lock holds.
                    if (a_req && b_req) grant_b = lock_ok || !last_b_q;
                    else                grant_b = b_req;

                    win_we   = grant_b ? b_we : a_we;
                    last_b_d = grant_b;
                    own_b_d  = grant_b;

                    if (!grant_b)     lock_cnt_d = 8'd0;
                    else if (lock_ok) lock_cnt_d = lock_cnt_q + 8'd1;
                    else if (!b_lock) lock_cnt_d = 8'd0;

                    if (win_we) begin
                        fx_waddr_d = grant_b ? b_addr  : a_addr;
                        fx_data_d  = grant_b ? b_wdata : a_wdata;
                        state_d    = S_WR;
                    end else begin
                        fx_raddr_d = grant_b ? b_addr : a_addr;
                        state_d    = S_RD;
                    end
                end
            end
            S_WR: state_d = S_IDLE;
            S_RD: begin
                if (RD_LAT == 0) begin
                    capture = 1'b1;
                    state_d = S_RDONE;
                end else begin
                    wait_d  = LAT_M1;
                    state_d = S_RWAIT;
                end
            end
            S_RWAIT: begin
                if (wait_q == 3'd0) begin
                    capture = 1'b1;
                    state_d = S_RDONE;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            S_RDONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Read data lands in the owner's register on entry to RDONE, valid with its ack.
        if (capture) begin
            if (own_b_q) b_rdata_d = fx_q;
            else         a_rdata_d = fx_q;
        end

        ack_any = (state_d == S_WR) || (state_d == S_RDONE);
        a_ack_d = ack_any && !own_b_d;
        b_ack_d = ack_any &&  own_b_d;
        fx_wr_d = (state_d == S_WR);
        fx_rd_d = (state_d == S_RD);
        busy_d  = (state_d != S_IDLE);
    end

    // NOTE: reset is sampled on the clock edge; state uses non-blocking assignments only.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_q     <= 3'd0;
            lock_cnt_q <= 8'd0;
            last_b_q   <= 1'b1;
            own_b_q    <= 1'b0;
            fx_waddr_q <= '0;
            fx_raddr_q <= '0;
            fx_data_q  <= '0;
            fx_wr_q    <= 1'b0;
            fx_rd_q    <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            lock_cnt_q <= lock_cnt_d;
            last_b_q   <= last_b_d;
            own_b_q    <= own_b_d;
            fx_waddr_q <= fx_waddr_d;
            fx_raddr_q <= fx_raddr_d;
            fx_data_q  <= fx_data_d;
            fx_wr_q    <= fx_wr_d;
            fx_rd_q    <= fx_rd_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign fx_waddr = fx_waddr_q;
    assign fx_raddr = fx_raddr_q;
    assign fx_data  = fx_data_q;
    assign fx_wr    = fx_wr_q;
    assign fx_rd    = fx_rd_q;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign busy     = busy_q;
    assign own_b    = own_b_q;

endmodule

// File: tb/tb_fx_arb.sv
// Scoreboard bench for fx_arb: one RD_LAT=1/LOCK_MAX=4 instance plus an RD_LAT=0
// instance for the zero-latency read path.
module tb_fx_arb;

    typedef struct {
        bit          port_b;
        bit          we;
        logic [21:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
    logic [21:0] a_addr = '0, b_addr = '0;
    logic [7:0]  a_wdata = '0, b_wdata = '0;

    logic        a_ack, b_ack, fx_wr, fx_rd, busy, own_b;
    logic [7:0]  a_rdata, b_rdata, fx_data;
    logic [21:0] fx_waddr, fx_raddr;
    logic [7:0]  fx_q = '0;

    logic        a_ack0, b_ack0, fx_wr0, fx_rd0, busy0, own_b0;
    logic [7:0]  a_rdata0, b_rdata0, fx_data0, fx_q0;
    logic [21:0] fx_waddr0, fx_raddr0;

    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b1;
    txn_t sb[$];

    always #5 clk_sys = ~clk_sys;

    function automatic logic [7:0] bank_rd(input logic [21:0] a);
        if (a == 22'h000020) return 8'hC3;
        return (a[7:0] + a[21:14]) ^ 8'h5C;
    endfunction

    fx_arb #(.RD_LAT(1), .LOCK_MAX(4)) u_dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_lock(b_lock),
        .fx_waddr(fx_waddr), .fx_wr(fx_wr), .fx_data(fx_data),
        .fx_rd(fx_rd), .fx_raddr(fx_raddr), .fx_q(fx_q),
        .busy(busy), .own_b(own_b)
    );

    fx_arb #(.RD_LAT(0), .LOCK_MAX(4)) u_dut0 (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack0), .a_rdata(a_rdata0),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack0), .b_rdata(b_rdata0), .b_lock(b_lock),
        .fx_waddr(fx_waddr0), .fx_wr(fx_wr0), .fx_data(fx_data0),
        .fx_rd(fx_rd0), .fx_raddr(fx_raddr0), .fx_q(fx_q0),
        .busy(busy0), .own_b(own_b0)
    );

    // Bank models: registered one-cycle read for u_dut, combinational for u_dut0.
    always @(posedge clk_sys) if (fx_rd) fx_q <= bank_rd(fx_raddr);
    assign fx_q0 = bank_rd(fx_raddr0);

    // Monitor: pops the scoreboard on every ack of u_dut and checks bus invariants.
    logic prev_wr = 1'b0, prev_rd = 1'b0;
    always @(negedge clk_sys) begin
        if (mon_en) begin
            n_cmp++;
            if ((fx_wr && fx_rd) || (fx_wr && prev_wr) || (fx_rd && prev_rd) || (a_ack && b_ack)) begin
                n_err++;
                $display("FAIL strobe_rules: wr=%0b rd=%0b prev_wr=%0b prev_rd=%0b a_ack=%0b b_ack=%0b, required exclusive single-cycle strobes and acks",
                         fx_wr, fx_rd, prev_wr, prev_rd, a_ack, b_ack);
            end
            if (a_ack || b_ack) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b, required no ack", a_ack, b_ack);
                end else begin
                    txn_t e;
                    logic [33:0] obs, exp;
                    e = sb.pop_front();
                    if (e.we) begin
                        obs = {b_ack, own_b, fx_wr, fx_waddr, fx_data, 1'b0};
                        exp = {e.port_b, e.port_b, 1'b1, e.addr, e.data, 1'b0};
                    end else begin
                        obs = {b_ack, own_b, 1'b0, fx_raddr, (b_ack ? b_rdata : a_rdata), 1'b0};
                        exp = {e.port_b, e.port_b, 1'b0, e.addr, e.data, 1'b0};
                    end
                    if (obs !== exp) begin
                        n_err++;
                        $display("FAIL sb_txn: got {b,own_b,wr,addr,data}=%h, required %h", obs, exp);
                    end
                end
            end
        end
        prev_wr = fx_wr;
        prev_rd = fx_rd;
    end

    task automatic do_reset();
        @(negedge clk_sys);
        rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk_sys);
        n_cmp++;
        if ({fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr, a_ack, b_ack, a_rdata, b_rdata, busy, own_b} !== 74'd0 ||
            {fx_waddr0, fx_wr0, fx_data0, fx_rd0, fx_raddr0, a_ack0, b_ack0, a_rdata0, b_rdata0, busy0, own_b0} !== 74'd0) begin
            n_err++;
            $display("FAIL reset_outputs: waddr=%h raddr=%h data=%h ack=%0b%0b busy=%0b own_b=%0b, required all 0",
                     fx_waddr, fx_raddr, fx_data, a_ack, b_ack, busy, own_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_write_a();
        a_req = 1'b1; a_we = 1'b1; a_addr = 22'h000010; a_wdata = 8'h5A;
        sb.push_back('{port_b: 1'b0, we: 1'b1, addr: 22'h000010, data: 8'h5A});
        @(negedge clk_sys);
        a_req = 1'b0;
        n_cmp++;
        if ({a_ack, b_ack, fx_wr, busy, fx_waddr, fx_data} !== {4'b1011, 22'h000010, 8'h5A}) begin
            n_err++;
            $display("FAIL write_a_cycle: ack_a/b,wr,busy=%b%b%b%b addr=%h data=%h, required 1011 000010 5a",
                     a_ack, b_ack, fx_wr, busy, fx_waddr, fx_data);
        end
        @(negedge clk_sys);
        n_cmp++;
        if ({a_ack, b_ack, fx_wr, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL write_a_single: ack_a/b,wr,busy=%b%b%b%b, required 0000", a_ack, b_ack, fx_wr, busy);
        end
    endtask

    task automatic test_read_b();
        logic [7:0] a_keep;
        a_keep = a_rdata;
        b_req = 1'b1; b_we = 1'b0; b_addr = 22'h000020;
        sb.push_back('{port_b: 1'b1, we: 1'b0, addr: 22'h000020, data: 8'hC3});
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_sys);
            b_req = 1'b0;
            n_cmp++;
            if (c == 1 && {fx_rd, fx_raddr, b_ack} !== {1'b1, 22'h000020, 1'b0}) begin
                n_err++;
                $display("FAIL read_b_strobe: rd=%0b raddr=%h b_ack=%0b, required 1 000020 0", fx_rd, fx_raddr, b_ack);
            end else if (c == 2 && {fx_rd, b_ack} !== 2'b00) begin
                n_err++;
                $display("FAIL read_b_wait: rd=%0b b_ack=%0b, required 0 0", fx_rd, b_ack);
            end else if (c == 3 && {b_ack, a_ack, b_rdata, a_rdata} !== {2'b10, 8'hC3, a_keep}) begin
                n_err++;
                $display("FAIL read_b_done: b_ack=%0b a_ack=%0b b_rdata=%h a_rdata=%h, required 1 0 c3 %h",
                         b_ack, a_ack, b_rdata, a_rdata, a_keep);
            end
        end
    endtask

    // Both ports write continuously; order list gives the expected grant sequence,
    // lock_on/lock_off are the ack counts after which b_lock is raised/dropped.
    task automatic run_contention(input string name, input bit order[], input int lock_on, input int lock_off);
        int acks;
        acks = 0;
        a_we = 1'b1; a_addr = 22'h000100; a_wdata = 8'h11;
        b_we = 1'b1; b_addr = 22'h000200; b_wdata = 8'h22;
        foreach (order[i])
            sb.push_back('{port_b: order[i], we: 1'b1,
                           addr: order[i] ? 22'h000200 : 22'h000100,
                           data: order[i] ? 8'h22 : 8'h11});
        a_req = 1'b1; b_req = 1'b1;
        for (int c = 0; c < 200 && acks < order.size(); c++) begin
            @(negedge clk_sys);
            if (a_ack || b_ack) begin
                acks++;
                if (acks == lock_on)  b_lock = 1'b1;
                if (acks == lock_off) b_lock = 1'b0;
                if (acks == order.size()) begin a_req = 1'b0; b_req = 1'b0; end
            end
        end
        a_req = 1'b0; b_req = 1'b0; b_lock = 1'b0;
        repeat (4) @(negedge clk_sys);
        n_cmp++;
        if (acks != order.size() || sb.size() != 0) begin
            n_err++;
            $display("FAIL %s: acks=%0d pending=%0d, required %0d acks and 0 pending", name, acks, sb.size(), order.size());
        end
    endtask

    task automatic test_round_robin();
        bit order[] = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        run_contention("round_robin", order, 0, 0);
    endtask

    task automatic test_lock();
        bit order[] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        run_contention("lock_override", order, 1, 8);
    endtask

    task automatic test_reset_mid_read();
        bit seen;
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 22'h000055;
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b0; a_req = 1'b0;
        @(negedge clk_sys);
        n_cmp++;
        if ({fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr, a_ack, b_ack, a_rdata, b_rdata, busy, own_b} !== 74'd0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: raddr=%h rd=%0b a_ack=%0b busy=%0b, required all 0", fx_raddr, fx_rd, a_ack, busy);
        end
        rst_n = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 22'h000077; a_wdata = 8'h3C;
        sb.push_back('{port_b: 1'b0, we: 1'b1, addr: 22'h000077, data: 8'h3C});
        seen = 1'b0;
        for (int c = 0; c < 2 && !seen; c++) begin
            @(negedge clk_sys);
            if (a_ack) begin seen = 1'b1; a_req = 1'b0; end
        end
        a_req = 1'b0;
        repeat (3) @(negedge clk_sys);
        n_cmp++;
        if ({seen, a_rdata} !== {1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL mid_reset_recover: write_acked=%0b a_rdata=%h, required 1 00", seen, a_rdata);
        end
    endtask

    task automatic test_back_to_back_lat0();
        txn_t q0[$];
        int   done, cyc, rd_cyc;
        txn_t e;
        mon_en = 1'b0;
        do_reset();
        a_req = 1'b1; a_we = 1'b0; a_addr = 22'h3FFFFF;
        q0.push_back('{port_b: 1'b0, we: 1'b0, addr: 22'h3FFFFF, data: bank_rd(22'h3FFFFF)});
        done = 0; cyc = 0; rd_cyc = -10;
        for (int c = 0; c < 20 && done < 2; c++) begin
            @(negedge clk_sys);
            cyc++;
            if (fx_rd0) rd_cyc = cyc;
            if (a_ack0) begin
                done++;
                n_cmp++;
                if (q0.size() == 0) begin
                    n_err++;
                    $display("FAIL lat0_unexpected_ack: a_ack0=1, required 0");
                end else begin
                    e = q0.pop_front();
                    if ({a_rdata0, fx_raddr0, b_ack0} !== {e.data, e.addr, 1'b0} ||
                        cyc - rd_cyc != 1 || (done == 1 && cyc != 2)) begin
                        n_err++;
                        $display("FAIL lat0_read%0d: rdata=%h raddr=%h b_ack=%0b cyc=%0d rd_cyc=%0d, required %h %h 0 ack one cycle after fx_rd",
                                 done, a_rdata0, fx_raddr0, b_ack0, cyc, rd_cyc, e.data, e.addr);
                    end
                end
                if (done == 1) begin
                    a_addr = 22'h000000;
                    q0.push_back('{port_b: 1'b0, we: 1'b0, addr: 22'h000000, data: bank_rd(22'h000000)});
                end else begin
                    a_req = 1'b0;
                end
            end
        end
        a_req = 1'b0;
        n_cmp++;
        if (done != 2) begin
            n_err++;
            $display("FAIL lat0_timeout: acks=%0d, required 2", done);
        end
        do_reset();
        mon_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write_a();
        test_read_b();
        test_round_robin();
        test_lock();
        test_reset_mid_read();
        test_back_to_back_lat0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
